// File: rtl/rx_level_monitor.sv
// Per-lane receive-level monitor for the AD9361 sample path: |sample| pipeline,
// threshold hit counting, peak tracking, sticky/windowed reporting, LEDs and MCU readout.
module rx_level_monitor #(
    parameter int NUM_LANES   = 8,
    parameter int DATA_WIDTH  = 12,
    parameter int CNT_WIDTH   = 16,
    parameter int HIT_MIN     = 2,
    parameter int WINDOW_LOG2 = 24,
    parameter int SEL_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            d_clk,
    input  logic                            reset,
    input  logic [NUM_LANES-1:0]            in_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0]           threshold,
    input  logic                            mode,
    input  logic                            clear,
    output logic [NUM_LANES-1:0]            led,
    input  logic [SEL_W-1:0]                rd_sel,
    output logic [CNT_WIDTH-1:0]            rd_count,
    output logic [DATA_WIDTH-1:0]           rd_peak
);

    localparam int                   SEL_SPAN  = 1 << SEL_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] HIT_MIN_C = CNT_WIDTH'(HIT_MIN);

    logic                   mode_reg;
    logic                   mode_armed_reg;
    logic                   flush;
    logic [WINDOW_LOG2-1:0] win_ctr_reg;
    logic                   win_wrap;

    // Reported values per selectable index; indices past the last lane read as zero.
    logic [CNT_WIDTH-1:0]   rep_cnt  [SEL_SPAN];
    logic [DATA_WIDTH-1:0]  rep_peak [SEL_SPAN];

    // The first cycle after reset only records mode, so a strapped windowed mode
    // is not mistaken for a change.
    always_ff @(posedge d_clk) begin
        if (reset) begin
            mode_reg       <= 1'b0;
            mode_armed_reg <= 1'b0;
        end else begin
            mode_reg       <= mode;
            mode_armed_reg <= 1'b1;
        end
    end

    assign flush = clear | (mode_armed_reg & (mode ^ mode_reg));

    always_ff @(posedge d_clk) begin
        if (reset || flush) begin
            win_ctr_reg <= '0;
        end else begin
            win_ctr_reg <= win_ctr_reg + WINDOW_LOG2'(1);
        end
    end

    assign win_wrap = mode & (&win_ctr_reg);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] sample;
            logic [DATA_WIDTH-1:0] mag_reg;
            logic                  valid_reg;
            logic                  hit;
            logic [CNT_WIDTH-1:0]  live_cnt_reg;
            logic [CNT_WIDTH-1:0]  live_cnt_next;
            logic [CNT_WIDTH-1:0]  hold_cnt_reg;
            logic [CNT_WIDTH-1:0]  rep_cnt_lane;
            logic [DATA_WIDTH-1:0] live_peak_reg;
            logic [DATA_WIDTH-1:0] live_peak_next;
            logic [DATA_WIDTH-1:0] hold_peak_reg;
            logic [DATA_WIDTH-1:0] rep_peak_lane;
            logic                  led_reg;

            assign sample = in_data[gi*DATA_WIDTH +: DATA_WIDTH];

            // Negating in DATA_WIDTH bits maps the most-negative code onto
            // 2^(DATA_WIDTH-1), which is representable as an unsigned magnitude.
            always_ff @(posedge d_clk) begin
                if (reset) begin
                    mag_reg   <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    mag_reg   <= sample[DATA_WIDTH-1] ? (~sample + DATA_WIDTH'(1)) : sample;
                    valid_reg <= in_valid[gi];
                end
            end

            assign hit = valid_reg & (mag_reg > threshold);

            always_comb begin
                live_cnt_next  = live_cnt_reg;
                live_peak_next = live_peak_reg;
                if (hit && (live_cnt_reg != CNT_MAX)) begin
                    live_cnt_next = live_cnt_reg + CNT_WIDTH'(1);
                end
                if (valid_reg && (mag_reg > live_peak_reg)) begin
                    live_peak_next = mag_reg;
                end
            end

            assign rep_cnt_lane  = mode ? hold_cnt_reg  : live_cnt_reg;
            assign rep_peak_lane = mode ? hold_peak_reg : live_peak_reg;

            // On a window wrap the hold captures this cycle's result and live restarts.
            always_ff @(posedge d_clk) begin
                if (reset || flush) begin
                    live_cnt_reg  <= '0;
                    live_peak_reg <= '0;
                    hold_cnt_reg  <= '0;
                    hold_peak_reg <= '0;
                    led_reg       <= 1'b0;
                end else begin
                    if (win_wrap) begin
                        hold_cnt_reg  <= live_cnt_next;
                        hold_peak_reg <= live_peak_next;
                        live_cnt_reg  <= '0;
                        live_peak_reg <= '0;
                    end else begin
                        live_cnt_reg  <= live_cnt_next;
                        live_peak_reg <= live_peak_next;
                    end
                    led_reg <= (rep_cnt_lane >= HIT_MIN_C);
                end
            end

            assign led[gi]      = led_reg;
            assign rep_cnt[gi]  = rep_cnt_lane;
            assign rep_peak[gi] = rep_peak_lane;
        end

        for (genvar gi = NUM_LANES; gi < SEL_SPAN; gi++) begin : g_pad
            assign rep_cnt[gi]  = '0;
            assign rep_peak[gi] = '0;
        end
    endgenerate

    always_ff @(posedge d_clk) begin
        if (reset) begin
            rd_count <= '0;
            rd_peak  <= '0;
        end else begin
            rd_count <= rep_cnt[rd_sel];
            rd_peak  <= rep_peak[rd_sel];
        end
    end

endmodule

// File: tb/tb_rx_level_monitor.sv
// Bench for rx_level_monitor: two instances (default and small counters/window)
// checked every cycle against a behavioural model, plus directed scenario checks.
module tb_rx_level_monitor;

    logic        d_clk;
    logic        reset;
    logic [7:0]  in_valid;
    logic [95:0] in_data;
    logic [11:0] threshold;
    logic        mode;
    logic        clear;
    logic [2:0]  rd_sel;

    logic [7:0]  led0;
    logic [15:0] rd_count0;
    logic [11:0] rd_peak0;
    logic [5:0]  led1;
    logic [3:0]  rd_count1;
    logic [11:0] rd_peak1;

    int n_tests = 0;
    int n_fail  = 0;

    rx_level_monitor #(
        .NUM_LANES(8), .DATA_WIDTH(12), .CNT_WIDTH(16), .HIT_MIN(2), .WINDOW_LOG2(24)
    ) dut0 (
        .d_clk(d_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .threshold(threshold), .mode(mode), .clear(clear), .led(led0),
        .rd_sel(rd_sel), .rd_count(rd_count0), .rd_peak(rd_peak0)
    );

    rx_level_monitor #(
        .NUM_LANES(6), .DATA_WIDTH(12), .CNT_WIDTH(4), .HIT_MIN(2), .WINDOW_LOG2(4)
    ) dut1 (
        .d_clk(d_clk), .reset(reset), .in_valid(in_valid[5:0]), .in_data(in_data[71:0]),
        .threshold(threshold), .mode(mode), .clear(clear), .led(led1),
        .rd_sel(rd_sel), .rd_count(rd_count1), .rd_peak(rd_peak1)
    );

    initial begin
        d_clk = 1'b0;
        forever #5 d_clk = ~d_clk;
    end

    // ---------------- behavioural model ----------------
    int     NL   [2] = '{8, 6};
    int     CMAX [2] = '{65535, 15};
    int     WL   [2] = '{24, 4};
    int     live_c [2][8];
    int     live_p [2][8];
    int     hold_c [2][8];
    int     hold_p [2][8];
    int     s1_mag [8];
    bit     s1_vld [8];
    logic [7:0] exp_led [2];
    int     exp_rdc [2];
    int     exp_rdp [2];
    longint win_age;
    bit     armed;
    bit     mode_prev;

    task automatic model_step();
        logic signed [11:0] sx;
        int     v, rc, nc, np;
        bit     fl, wrap;
        longint per;
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                for (int k = 0; k < 8; k++) begin
                    live_c[u][k] = 0; live_p[u][k] = 0;
                    hold_c[u][k] = 0; hold_p[u][k] = 0;
                end
                exp_led[u] = '0; exp_rdc[u] = 0; exp_rdp[u] = 0;
            end
            for (int k = 0; k < 8; k++) begin
                s1_mag[k] = 0; s1_vld[k] = 1'b0;
            end
            win_age = 0; armed = 1'b0; mode_prev = 1'b0;
            return;
        end
        fl = clear || (armed && (mode != mode_prev));
        for (int u = 0; u < 2; u++) begin
            // outputs are registered from what is reported before this edge
            for (int k = 0; k < NL[u]; k++) begin
                rc = mode ? hold_c[u][k] : live_c[u][k];
                exp_led[u][k] = !fl && (rc >= 2);
            end
            if (int'(rd_sel) < NL[u]) begin
                exp_rdc[u] = mode ? hold_c[u][rd_sel] : live_c[u][rd_sel];
                exp_rdp[u] = mode ? hold_p[u][rd_sel] : live_p[u][rd_sel];
            end else begin
                exp_rdc[u] = 0;
                exp_rdp[u] = 0;
            end
            per  = longint'(1) << WL[u];
            wrap = mode && ((win_age % per) == per - 1);
            for (int k = 0; k < NL[u]; k++) begin
                if (fl) begin
                    live_c[u][k] = 0; live_p[u][k] = 0;
                    hold_c[u][k] = 0; hold_p[u][k] = 0;
                end else begin
                    nc = live_c[u][k];
                    np = live_p[u][k];
                    if (s1_vld[k] && s1_mag[k] > int'(threshold)) nc = (nc < CMAX[u]) ? nc + 1 : nc;
                    if (s1_vld[k] && s1_mag[k] > np) np = s1_mag[k];
                    if (wrap) begin
                        hold_c[u][k] = nc; hold_p[u][k] = np;
                        live_c[u][k] = 0;  live_p[u][k] = 0;
                    end else begin
                        live_c[u][k] = nc; live_p[u][k] = np;
                    end
                end
            end
        end
        win_age = fl ? 0 : win_age + 1;
        for (int k = 0; k < 8; k++) begin
            s1_vld[k] = in_valid[k];
            sx = in_data[k*12 +: 12];
            v  = sx;
            s1_mag[k] = (v < 0) ? -v : v;
        end
        mode_prev = mode;
        armed     = 1'b1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Directed checks also log one line per transaction.
    task automatic dcheck(input string name, input longint act, input longint exp);
        check(name, act, exp);
        $display("[TB] %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Single compare process: model advances on each edge, DUT sampled 1 time unit later.
    always @(posedge d_clk) begin
        model_step();
        #1;
        check("led0",      led0,      exp_led[0]);
        check("rd_count0", rd_count0, exp_rdc[0]);
        check("rd_peak0",  rd_peak0,  exp_rdp[0]);
        check("led1",      led1,      exp_led[1][5:0]);
        check("rd_count1", rd_count1, exp_rdc[1]);
        check("rd_peak1",  rd_peak1,  exp_rdp[1]);
    end

    // ---------------- stimulus ----------------
    function automatic logic [11:0] s12(input int v);
        logic [31:0] t;
        t = v;
        return t[11:0];
    endfunction

    task automatic cyc();
        @(posedge d_clk);
        @(negedge d_clk);
    endtask

    task automatic idle();
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic put(input int k, input int v);
        in_valid[k]         = 1'b1;
        in_data[k*12 +: 12] = s12(v);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        logic [11:0] d;
        reset = 1'b1; clear = 1'b0; mode = 1'b0; threshold = '0;
        in_valid = '0; in_data = '0; rd_sel = '0;
        repeat (3) cyc();
        dcheck("reset_led0", led0, 0);
        dcheck("reset_rd_count0", rd_count0, 0);
        dcheck("reset_rd_peak1", rd_peak1, 0);
        reset = 1'b0;

        // saturation detect: three most-negative samples on lane 0
        threshold = 12'd2000;
        for (int i = 0; i < 3; i++) begin
            idle(); put(0, -2048); cyc();
        end
        idle();
        repeat (4) cyc();
        dcheck("sat_rd_count0", rd_count0, 3);
        dcheck("sat_rd_peak0", rd_peak0, 2048);
        dcheck("sat_led0_lane0", led0[0], 1);
        dcheck("sat_led0_others", led0[7:1], 0);
        dcheck("model_pin_cnt", exp_rdc[0], 3);
        dcheck("model_pin_peak", exp_rdp[0], 2048);
        rd_sel = 3'd5;
        cyc();
        dcheck("sat_lane5_count", rd_count0, 0);

        // threshold edge: +-2000 no hit, +-2001 hit
        rd_sel = 3'd0;
        pulse_clear();
        idle(); put(0, 2000);  cyc();
        idle(); put(0, -2000); cyc();
        idle();
        repeat (3) cyc();
        dcheck("thr_equal_count", rd_count0, 0);
        put(0, 2001); cyc();
        idle(); put(0, -2001); cyc();
        idle(); cyc();
        dcheck("thr_led_n2", led0[0], 0);
        cyc();
        dcheck("thr_led_n3", led0[0], 1);
        dcheck("thr_count", rd_count0, 2);
        dcheck("thr_peak", rd_peak0, 2001);

        // counter saturation on the 4-bit instance
        rd_sel = 3'd1;
        pulse_clear();
        for (int i = 0; i < 20; i++) begin
            idle(); put(1, 2001); cyc();
        end
        idle();
        repeat (4) cyc();
        dcheck("cntsat_rd_count1", rd_count1, 15);
        dcheck("cntsat_rd_count0", rd_count0, 20);

        // windowed: 5 hits in window 1, none in window 2
        rd_sel = 3'd2;
        mode = 1'b1;
        cyc();
        for (int i = 0; i <= 40; i++) begin
            idle();
            if (i >= 1 && i <= 5) put(2, 2047);
            cyc();
            if (i == 19) begin
                dcheck("win1_rd_count1", rd_count1, 5);
                dcheck("win1_led1", led1[2], 1);
                dcheck("win1_rd_count0", rd_count0, 0);
            end
            if (i == 39) begin
                dcheck("win2_rd_count1", rd_count1, 0);
                dcheck("win2_led1", led1[2], 0);
            end
        end

        // clear collision: hit in stage 2 dropped, hit in stage 1 kept
        mode = 1'b0;
        rd_sel = 3'd3;
        cyc();
        idle(); put(3, 2047); cyc();
        clear = 1'b1; put(3, 2047); cyc();
        clear = 1'b0; idle();
        repeat (4) cyc();
        dcheck("clr_rd_count0", rd_count0, 1);
        dcheck("clr_rd_count1", rd_count1, 1);
        dcheck("clr_rd_peak0", rd_peak0, 2047);

        // reset mid-run in windowed mode, then window restarts from 0
        rd_sel = 3'd4;
        mode = 1'b1;
        cyc();
        for (int i = 0; i < 40; i++) begin
            idle(); put(4, 2047); cyc();
        end
        idle();
        dcheck("prerst_nonzero", (rd_count1 != 0) ? 1 : 0, 1);
        reset = 1'b1;
        cyc();
        dcheck("rst_led0", led0, 0);
        dcheck("rst_led1", led1, 0);
        dcheck("rst_rd_count1", rd_count1, 0);
        dcheck("rst_rd_peak1", rd_peak1, 0);
        reset = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            idle();
            if (i >= 1 && i <= 3) put(4, 2047);
            cyc();
            if (i == 15) dcheck("restart_c16", rd_count1, 0);
            if (i == 16) dcheck("restart_c17", rd_count1, 3);
        end

        // randomized traffic, model-checked every cycle
        threshold = 12'd1000;
        for (int c = 0; c < 3000; c++) begin
            in_valid = 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                sel = $urandom_range(0, 6);
                case (sel)
                    0:       d = 12'h800;
                    1:       d = 12'h7FF;
                    2:       d = threshold;
                    3:       d = ~threshold + 12'd1;
                    4:       d = threshold + 12'd1;
                    default: d = 12'($urandom);
                endcase
                in_data[k*12 +: 12] = d;
            end
            if ($urandom_range(0, 49) == 0) threshold = 12'($urandom_range(0, 2047));
            rd_sel = 3'($urandom);
            clear  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 149) == 0) mode = ~mode;
            reset  = ($urandom_range(0, 699) == 0);
            cyc();
        end
        reset = 1'b0; clear = 1'b0; idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_level_monitor.md
# rx_level_monitor

Parametrised per-lane receive-level monitor for the AD9361 sample path, running in the d_clk domain beside the sample filter. It takes any number of signed I/Q lanes and computes absolute magnitude with a correct most-negative case. It counts samples above a programmable threshold with saturating counters and tracks peak magnitude. It drives one status LED per lane, in sticky or windowed mode, and the MCU can read each lane's count and peak through a registered select port.

## Interface
- NUM_LANES, 8, number of monitored lanes (I and Q of each channel are separate lanes)
- DATA_WIDTH, 12, sample width, two's complement
- CNT_WIDTH, 16, hit-counter width
- HIT_MIN, 2, LED asserts when reported count >= HIT_MIN
- WINDOW_LOG2, 24, window length 2^WINDOW_LOG2 d_clk cycles (windowed mode)
- SEL_W, $clog2(NUM_LANES), read-select width
- d_clk  in  1  data clock; all logic on posedge
- reset  in  1  reset, synchronous, active-high; clock d_clk
- in_valid  in  NUM_LANES  per-lane sample strobe
- in_data  in  NUM_LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- threshold  in  DATA_WIDTH  unsigned magnitude threshold, quasi-static
- mode  in  1  0 = sticky, 1 = windowed
- clear  in  1  single-cycle pulse, clears all counts, peaks, holds, window
- led  out  NUM_LANES  per-lane level indicator
- rd_sel  in  SEL_W  lane to read
- rd_count  out  CNT_WIDTH  reported hit count of lane rd_sel
- rd_peak  out  DATA_WIDTH  reported peak magnitude of lane rd_sel

## Operation
- Stage 1: mag_k = in_data_k[MSB] ? (~in_data_k + 1) : in_data_k, computed unsigned at DATA_WIDTH bits. The most-negative input gives 2^(DATA_WIDTH-1) with no wrap. Both mag_k and valid_k are registered.
- Stage 2, per lane with a registered valid: hit = mag > threshold, strictly greater. On hit, live_cnt increments and saturates at 2^CNT_WIDTH-1. live_peak takes max(live_peak, mag). A sample with valid low has no effect.
- Sticky mode: reported count and peak are live_cnt and live_peak. They accumulate until clear, reset, or a mode change.
- Windowed mode: win_ctr counts every d_clk and wraps at 2^WINDOW_LOG2-1.
  - On the wrap cycle, hold_cnt and hold_peak take the final live values including any hit in that cycle's stage 2.
  - On the following cycle, live_cnt and live_peak restart from 0.
  - Reported count and peak are hold_cnt and hold_peak.
- led_k is registered: 1 when reported count_k >= HIT_MIN.
- Readout: rd_count and rd_peak are registered from the reported values of lane rd_sel. An out-of-range rd_sel (>= NUM_LANES) returns 0.
- clear, or any change of mode (detected against a registered copy), zeroes all live and hold registers, win_ctr, and led. A clear wins over a hit in the same cycle. The pipeline stage-1 registers are not cleared.
- reset zeroes everything, including the pipeline and the registered mode copy. mode after reset takes effect with no spurious clear pulse.

## Timing
- Reset values: led = 0, rd_count = 0, rd_peak = 0, all internal state 0.
- A sample on in_valid at cycle n is reflected in live_cnt and live_peak at n+2.
  - Sticky mode: led and rd_count/rd_peak update at n+3.
- The wrap at cycle w makes hold valid at w+1; led and rd_* reflect it at w+2.
- A change on rd_sel at cycle n gives rd_count/rd_peak for that lane at n+1.
- A clear at cycle n gives led = 0 and rd_* = 0 from n+2. Samples in stage 1 at n still count after the clear.
- All lanes update independently and simultaneously; there is no arbitration.
- threshold is sampled at stage 2 each cycle. A change mid-stream applies to samples in stage 2 from the next cycle.

## Test plan
- Saturation detect, default params, sticky: lane 0 gets 3 valid samples of 12'h800, threshold = 2000. rd_sel = 0 reads rd_count = 3, rd_peak = 2048 (no wrap to 0), and led[0] = 1. Lanes 1-7 read rd_count = 0 and led = 0.
- Threshold edge: samples of +2000 and -2000 with threshold 2000 give count 0. Samples of +2001 and -2001 give count 2. With HIT_MIN = 2, led rises exactly at n+3 after the second hit.
- Counter saturation: CNT_WIDTH = 4 with 20 continuous hits gives rd_count = 15 and no wrap.
- Windowed mode: WINDOW_LOG2 = 4 with 5 hits inside window 1 and 0 hits in window 2. rd_count = 5 from w1+2 until the second wrap, then 0. led follows.
- Clear collision: assert clear in the same cycle a lane's hit is in stage 2 → count stays 0. A hit entering stage 1 that cycle still counts → rd_count = 1.
- Reset mid-run: assert reset with counts nonzero in windowed mode → all outputs 0 the next cycle, and the window restarts from 0 after release.
